// File: rtl/i2c_target_pcf8574_pkg.sv
// Shared constants for the PCF8574-style I2C target: FSM encoding, default address, ACK levels.
package i2c_target_pcf8574_pkg;

    localparam logic [6:0] I2C_ADDR_PCF8574 = 7'h27;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

endpackage

// File: rtl/i2c_target_pcf8574_line_sync.sv
// 2-FF synchronizer for one bus line with rise/fall pulses; 2 clk to sync_o, edge pulses one clk wide.
// No backpressure: free-running sampler, resets to the idle-high bus level.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/i2c_target_pcf8574.sv
// PCF8574-style I2C target: 8-bit quasi-port written/read over I2C, open-drain SDA drive.
// Reacts ~3 clk after each bus edge; the master paces everything, the target never stretches SCL.
module i2c_target_pcf8574
    import i2c_target_pcf8574_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_ADDR_PCF8574,
    parameter logic [7:0] PORT_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] port_out,
    input  logic [7:0] port_in,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl),
        .sync_o (scl_s),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .sync_o (sda_s),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic       start_det, stop_det;
    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] shift_in;
    logic       oe_q, oe_d;
    logic [7:0] port_q, port_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       rw_q, rw_d;
    logic       ph_q, ph_d;

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign shift_in  = {shift_q[6:0], sda_s};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        oe_d    = oe_q;
        port_d  = port_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rw_d    = rw_q;
        ph_d    = ph_q;

        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            ph_d    = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            shift_d = 8'd0;
            ph_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ph_d = 1'b0;
                            rw_d = sda_s;
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                if (sda_s) begin
                                    shift_d = port_in;
                                    rd_d    = 1'b1;
                                end
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // ph_q marks the ninth clock: first fall grabs SDA, second fall hands it on.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d = 1'b1;
                            ph_d = 1'b1;
                        end else begin
                            ph_d  = 1'b0;
                            cnt_d = 3'd0;
                            if (rw_q) begin
                                state_d = ST_RD_DATA;
                                oe_d    = ~shift_q[7];
                            end else begin
                                state_d = ST_WR_DATA;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            port_d  = shift_in;
                            wr_d    = 1'b1;
                            ph_d    = 1'b0;
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d = 1'b1;
                            ph_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            ph_d    = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = ST_WR_DATA;
                        end
                    end
                end
                // MSB already on the bus at entry; each fall presents the next bit.
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            cnt_d   = 3'd0;
                            ph_d    = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 3'd1;
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && !ph_q) begin
                        if (sda_s == ACK_BIT) begin
                            shift_d = port_in;
                            rd_d    = 1'b1;
                            ph_d    = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ph_q) begin
                        oe_d    = ~shift_q[7];
                        ph_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = ST_RD_DATA;
                    end
                end
                ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'd0;
            oe_q    <= 1'b0;
            port_q  <= PORT_RESET;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rw_q    <= 1'b0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            oe_q    <= oe_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            ph_q    <= ph_d;
        end
    end

    assign sda_oe    = oe_q;
    assign port_out  = port_q;
    assign wr_strobe = wr_q;
    assign rd_strobe = rd_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);

endmodule

// File: tb/tb_i2c_target_pcf8574.sv
// Directed bench for i2c_target_pcf8574: a bit-banged I2C master drives an open-drain bus model.
module tb_i2c_target_pcf8574;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] port_out;
    logic [7:0] port_in;
    logic       wr_strobe;
    logic       rd_strobe;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    int glitch_cnt = 0;
    logic [7:0] wr_log [64];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target_pcf8574 #(
        .SLAVE_ADDR (7'h27),
        .PORT_RESET (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .port_out  (port_out),
        .port_in   (port_in),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (wr_strobe === 1'b1) begin
            wr_log[wr_cnt % 64] <= port_out;
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_strobe === 1'b1) rd_cnt <= rd_cnt + 1;
        if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    // The target must never move SDA while SCL is high (reset excepted).
    always @(sda_oe) begin
        if (rst_n === 1'b1 && scl === 1'b1) glitch_cnt <= glitch_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        m_sda = 1'b0;
        wclk(8);
        scl = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        m_sda = 1'b1;
        wclk(8);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda = b;
        wclk(4);
        scl = 1'b1;
        wclk(6);
        s = sda_bus;
        wclk(2);
        scl = 1'b0;
        wclk(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(ack_bit, s);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_port;
        int         exp_wr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic       a, d;
        logic [7:0] rb;
        int         w0, r0, o0;

        vecs[0] = '{7'h27, 8'hA5, 1'b1, 8'hA5, 1};
        vecs[1] = '{7'h26, 8'h3C, 1'b0, 8'hA5, 0};
        vecs[2] = '{7'h67, 8'h00, 1'b0, 8'hA5, 0};
        vecs[3] = '{7'h27, 8'h00, 1'b1, 8'h00, 1};
        vecs[4] = '{7'h23, 8'hFF, 1'b0, 8'h00, 0};
        vecs[5] = '{7'h27, 8'hFF, 1'b1, 8'hFF, 1};

        rst_n   = 1'b0;
        scl     = 1'b1;
        m_sda   = 1'b1;
        port_in = 8'h00;
        wclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_port_out", port_out, 8'hFF);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_rd_strobe", rd_strobe, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wclk(4);

        for (int i = 0; i < 6; i++) begin
            w0 = wr_cnt;
            o0 = oe_cnt;
            i2c_start();
            write_byte({vecs[i].addr, 1'b0}, a);
            check($sformatf("vec%0d_addr_ack", i), a, vecs[i].exp_ack);
            check($sformatf("vec%0d_busy_mid", i), busy, vecs[i].exp_ack);
            write_byte(vecs[i].data, d);
            check($sformatf("vec%0d_data_ack", i), d, vecs[i].exp_ack);
            i2c_stop();
            wclk(4);
            check($sformatf("vec%0d_port_out", i), port_out, vecs[i].exp_port);
            check($sformatf("vec%0d_wr_pulses", i), wr_cnt - w0, vecs[i].exp_wr);
            check($sformatf("vec%0d_oe_used", i), oe_cnt != o0, vecs[i].exp_ack);
            check($sformatf("vec%0d_busy_end", i), busy, 0);
        end

        // Read 0x3C twice: master ACKs the first byte, NACKs the second.
        port_in = 8'h3C;
        r0 = rd_cnt;
        i2c_start();
        write_byte({7'h27, 1'b1}, a);
        check("rd_addr_ack", a, 1);
        read_byte(1'b0, rb);
        check("rd_byte0", rb, 8'h3C);
        read_byte(1'b1, rb);
        check("rd_byte1", rb, 8'h3C);
        check("rd_pulses", rd_cnt - r0, 2);
        check("rd_released_after_nack", sda_oe, 0);
        check("rd_busy_after_nack", busy, 0);
        i2c_stop();
        wclk(4);

        // Two data bytes in one write transfer.
        w0 = wr_cnt;
        i2c_start();
        write_byte({7'h27, 1'b0}, a);
        check("wr2_addr_ack", a, 1);
        write_byte(8'h11, d);
        check("wr2_port_first", port_out, 8'h11);
        write_byte(8'h22, d);
        check("wr2_data_ack", d, 1);
        i2c_stop();
        wclk(4);
        check("wr2_pulses", wr_cnt - w0, 2);
        check("wr2_log0", wr_log[w0 % 64], 8'h11);
        check("wr2_log1", wr_log[(w0 + 1) % 64], 8'h22);
        check("wr2_port_final", port_out, 8'h22);

        // Repeated START after four data bits, then a read.
        w0 = wr_cnt;
        port_in = 8'h96;
        i2c_start();
        write_byte({7'h27, 1'b0}, a);
        send_bit(1'b1, a);
        send_bit(1'b0, a);
        send_bit(1'b1, a);
        send_bit(1'b0, a);
        i2c_start();
        write_byte({7'h27, 1'b1}, a);
        check("rs_addr_ack", a, 1);
        read_byte(1'b1, rb);
        check("rs_read_byte", rb, 8'h96);
        i2c_stop();
        wclk(4);
        check("rs_port_unchanged", port_out, 8'h22);
        check("rs_no_wr", wr_cnt - w0, 0);

        // Reset while the target holds the address ACK of a read.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b1 : ((8'h4E >> i) & 1'b1), a);
        check("rstmid_oe_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_oe_async", sda_oe, 0);
        check("rstmid_port_out", port_out, 8'hFF);
        check("rstmid_busy", busy, 0);
        wclk(2);
        rst_n = 1'b1;
        wclk(4);
        m_sda = 1'b1;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        check("rstmid_idle_oe", sda_oe, 0);
        i2c_start();
        write_byte({7'h27, 1'b0}, a);
        check("rstmid_next_ack", a, 1);
        write_byte(8'h5A, d);
        i2c_stop();
        wclk(4);
        check("rstmid_next_port", port_out, 8'h5A);

        check("sda_change_scl_high", glitch_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_pcf8574.md
I2C_TARGET_PCF8574 -- requirements
Module: i2c_target_pcf8574

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h27, giving the 7-bit address the target answers to.
REQ-002 SHALL have parameter PORT_RESET, default 8'hFF, giving the port_out value after reset (PCF8574 power-on state).
REQ-003 clk  input  1  single system clock; all logic is on its rising edge; frequency SHALL be at least 8x the SCL frequency.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from the bus (asynchronous to clk).
REQ-006 sda_i  input  1  I2C data as sensed on the bus (asynchronous to clk).
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release SDA.
REQ-008 port_out  output  8  last data byte written by the master.
REQ-009 port_in  input  8  value returned to the master on read transfers.
REQ-010 wr_strobe  output  1  one-clk pulse when port_out is updated.
REQ-011 rd_strobe  output  1  one-clk pulse when port_in is sampled for a read byte.
REQ-012 busy  output  1  high from an addressed START until STOP.

Function
REQ-013 scl and sda_i SHALL each pass through a 2-FF synchronizer; edges SHALL be detected from the synchronized value and its one-cycle delayed copy.
REQ-014 START SHALL be detected as sync SDA falling while sync SCL is high; STOP as sync SDA rising while sync SCL is high.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 From any state: START -> ADDR with the bit counter cleared; STOP -> IDLE with sda_oe=0 and busy=0.
REQ-017 In ADDR, WR_DATA and RD_ACK, SDA SHALL be sampled on the sync SCL rising edge, MSB first, using a 3-bit counter plus a ninth-bit phase.
REQ-018 After the 8th address bit: if addr[7:1]==SLAVE_ADDR -> ADDR_ACK; else -> IGNORE, with sda_oe never asserted.
REQ-019 ACK: sda_oe SHALL rise on the SCL falling edge after the 8th bit and fall on the next SCL falling edge.
REQ-020 Exit from ADDR_ACK: R/W=0 -> WR_DATA; R/W=1 -> RD_DATA.
REQ-021 On the ADDR_ACK entry edge for a read, port_in SHALL be captured into the shift register and rd_strobe pulsed.
REQ-022 WR_DATA: on the 8th data-bit rising edge, port_out SHALL load the byte and wr_strobe SHALL pulse on the next clk; then -> WR_ACK (always ACK) -> WR_DATA for further bytes.
REQ-023 RD_DATA: sda_oe = ~shift_msb, updated on each SCL falling edge (first bit on the falling edge that ends the ACK); after the 8th bit, release SDA -> RD_ACK.
REQ-024 RD_ACK: sample the master's bit on the SCL rising edge.
  - ACK (0): recapture port_in, pulse rd_strobe -> RD_DATA.
  - NACK (1): -> IGNORE.
REQ-025 IGNORE: sda_oe=0; leave only on START or STOP.
REQ-026 busy SHALL be 1 in every state except IDLE and IGNORE.
REQ-027 An SDA change while SCL is high, other than START/STOP, SHALL never occur from the target: sda_oe changes only on sync SCL falling edges or on STOP.
REQ-028 A repeated START during any byte SHALL discard the partial byte; port_out stays unchanged.

Reset
REQ-029 While rst_n=0: state=IDLE, sda_oe=0, port_out=PORT_RESET, wr_strobe=0, rd_strobe=0, busy=0, counters and shift register=0, synchronizers=1.
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after deassertion the block SHALL wait for a START.

Structure
REQ-031 Shared package SHALL hold the state encoding, the I2C_ADDR_PCF8574=7'h27 constant and the ACK/NACK bit constants.
REQ-032 One sub-module, i2c_line_sync, SHALL implement the synchronizer plus rise/fall detection; it is instantiated once for scl and once for sda_i.

Verification
REQ-033 Write 0x27+W, data 0xA5, STOP -> ACK on the address and data bytes; port_out=0xA5; exactly one wr_strobe; busy falls at STOP.
REQ-034 Address 0x26+W -> sda_oe stays 0 for the whole transfer; port_out unchanged; busy=0.
REQ-035 0x27+R, port_in=0x3C, master ACK then NACK -> SDA bits read 0x3C, 0x3C; two rd_strobe pulses; SDA released after the NACK.
REQ-036 Write 0x27+W, 0x11, 0x22, STOP -> port_out=0x11 then 0x22; two wr_strobe pulses.
REQ-037 Repeated START after 4 data bits, then 0x27+R -> port_out unchanged; read proceeds normally.
REQ-038 rst_n pulsed low during a read ACK -> sda_oe=0 within the same cycle; port_out=0xFF; the next transfer after a START succeeds.
